fetch_unit: RTL

Instruction-fetch stage: owns the program counter, drives the address into the instruction memory, and captures the returned instruction and exception fields into a 2-entry fetch queue. The queue feeds decode over a valid/ready handshake. The block sits directly upstream of the instruction memory and between it and decode. It also accepts control-flow redirects (branch/jump) and trap redirects, which flush in-flight fetches.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/fetch_unit_if.sv | 49 ++++
 rtl/fetch_fifo.sv | 66 ++++++
 rtl/fetch_unit.sv | 91 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: exception causes, the canonical NOP, the fetch-stage
// state encoding and the fetch-queue entry layout.
package cpu_pkg;

    localparam logic [3:0]  EXC_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0]  EXC_INSTR_ACCESS     = 4'd1;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

    typedef enum logic {
        FETCH,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        exc_en;
        logic [3:0]  exc_code;
        logic [63:0] exc_val;
    } fetch_entry_t;

    function automatic logic is_misaligned(input logic [63:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory and decode-side signals of the fetch stage. The master
// modport is the fetch unit; the slave modport is the memory/decode environment.
interface fetch_unit_if;

    logic [63:0] pc_addr;
    logic [31:0] imem_instruction;
    logic        imem_exc_en;
    logic [3:0]  imem_exc_code;
    logic [63:0] imem_exc_val;

    logic        if_valid;
    logic        if_ready;
    logic [63:0] if_pc;
    logic [31:0] if_instr;
    logic        if_exc_en;
    logic [3:0]  if_exc_code;
    logic [63:0] if_exc_val;

    modport master (
        output pc_addr,
        input  imem_instruction,
        input  imem_exc_en,
        input  imem_exc_code,
        input  imem_exc_val,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_instr,
        output if_exc_en,
        output if_exc_code,
        output if_exc_val
    );

    modport slave (
        input  pc_addr,
        output imem_instruction,
        output imem_exc_en,
        output imem_exc_code,
        output imem_exc_val,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_instr,
        input  if_exc_en,
        input  if_exc_code,
        input  if_exc_val
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular fetch queue. Flush beats push and pop; a push is accepted
// when full only if a pop frees the head slot in the same cycle.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         valid,
    output logic         full
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    fetch_entry_t        mem [DEPTH];
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW-1:0]     wr_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign valid   = count_q != '0;
    assign full    = count_q == CntW'(DEPTH);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign rdata   = valid ? mem[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !rst) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, FETCH/HALT state machine, next-PC
// selection and misalignment check, feeding decode through a 2-entry queue.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    input  logic         redirect_en,
    input  logic [63:0]  redirect_pc,
    input  logic         trap_en,
    input  logic [63:0]  trap_pc
);

    fetch_state_e state_q;
    logic [63:0]  pc_q;
    fetch_entry_t fetch_entry;
    fetch_entry_t head;
    logic         head_valid;
    logic         q_full;
    logic         flush;
    logic         pop;
    logic         push;

    assign flush = redirect_en | trap_en;
    assign pop   = head_valid & bus.if_ready;
    assign push  = (state_q == FETCH) & ~rst & ~flush & (~q_full | pop);

    // A misaligned PC never reaches memory semantics: it overrides any imem fault.
    always_comb begin
        fetch_entry    = '0;
        fetch_entry.pc = pc_q;
        if (is_misaligned(pc_q)) begin
            fetch_entry.instr    = NOP_INSTR;
            fetch_entry.exc_en   = 1'b1;
            fetch_entry.exc_code = EXC_INSTR_MISALIGNED;
            fetch_entry.exc_val  = pc_q;
        end else begin
            fetch_entry.instr    = bus.imem_instruction;
            fetch_entry.exc_en   = bus.imem_exc_en;
            fetch_entry.exc_code = bus.imem_exc_code;
            fetch_entry.exc_val  = bus.imem_exc_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= FETCH;
        end else if (trap_en) begin
            pc_q    <= trap_pc;
            state_q <= FETCH;
        end else if (redirect_en) begin
            pc_q    <= redirect_pc;
            state_q <= FETCH;
        end else if (push) begin
            // A faulting entry parks the PC on the faulting address.
            if (fetch_entry.exc_en) begin
                state_q <= HALT;
            end else begin
                pc_q <= pc_q + 64'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (fetch_entry),
        .rdata (head),
        .valid (head_valid),
        .full  (q_full)
    );

    assign bus.pc_addr     = pc_q;
    assign bus.if_valid    = head_valid;
    assign bus.if_pc       = head.pc;
    assign bus.if_instr    = head.instr;
    assign bus.if_exc_en   = head.exc_en;
    assign bus.if_exc_code = head.exc_code;
    assign bus.if_exc_val  = head.exc_val;

endmodule
